sdf_stage_2: RTL
================

// Module: sdf_stage_2
// PURPOSE
//   Radix-2 single-path delay-feedback (SDF) butterfly stage for the 2-point delay stage of the FFT pipeline.
//   - Consumes the stage-control code and twiddle factors produced by the matching twiddle/control ROM.
//   - Forms x[n]+x[n+D] and (x[n]-x[n+D])*W.
//   - Emits one complex sample per cycle to the next stage.
// PARAMETERS
//   DATA_W  24  width of each real/imag data and twiddle word (two's complement)
//   FRAC_W  8   fractional bits of the twiddle format (1.0 = 1<<FRAC_W = 256)
//   DELAY   2   feedback delay-line depth in samples; half-period of the state pattern
// PORTS
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   in_valid   in   1       din_r/din_i carry a valid sample this cycle
//   din_r      in   DATA_W  input sample, real part
//   din_i      in   DATA_W  input sample, imaginary part
//   w_r        in   DATA_W  twiddle real part, fixed-point with FRAC_W fraction bits; aligned with state
//   w_i        in   DATA_W  twiddle imaginary part, same format
//   state      in   2       0 = fill, 1 = butterfly, 2 = twiddle-multiply, 3 = reserved
//   out_valid  out  1       dout_r/dout_i valid
//   dout_r     out  DATA_W  output sample, real part
//   dout_i     out  DATA_W  output sample, imaginary part
// BEHAVIOUR
//   Reset (async, rst_n=0)
//   - out_valid, dout_r, dout_i, all delay-line data and valid tags cleared to 0 immediately.
//   - Reset mid-frame discards the frame; no stale out_valid after release.
//   Delay line
//   - DELAY entries {re, im, tag}; head = oldest entry.
//   - On a shift, the head is consumed and the new entry appended.
//   State 0 (fill)
//   - Shift only when in_valid=1; push {din, tag=1}.
//   - No output: out_valid<=0.
//   State 1 (butterfly): shifts every cycle regardless of in_valid.
//   - a = head, b = din.
//   - Output sum = a+b; out_valid <= in_valid & head.tag.
//   - Push diff = a-b with tag = in_valid & head.tag.
//   State 2 (twiddle): shifts every cycle.
//   - Push {din, tag=in_valid}.
//   - Output head*W with out_valid <= head.tag.
//   - re = (a_r*w_r - a_i*w_i) >>> FRAC_W
//   - im = (a_r*w_i + a_i*w_r) >>> FRAC_W
//   - Full 2*DATA_W signed products; arithmetic right shift (floor); keep low DATA_W bits.
//   State 3: no shift, out_valid<=0, outputs hold.
//   Widths
//   - Add/sub results wrap to DATA_W (no growth, no saturation).
//   - Upstream scaling prevents overflow.
//   Latency
//   - Outputs registered: 1 cycle from the state-1/2 cycle that produces them.
//   - dout_r/dout_i hold their last value while out_valid=0.
//   Control
//   - States follow the pattern 0,0 (DELAY fill samples), then 1 x DELAY, 2 x DELAY repeating.
//   - The control source keeps cycling after in_valid drops.
//   - The stage therefore drains its delay line through state 2 with no extra flush logic.
//   - Tags suppress out_valid for samples pushed without in_valid.
//   - A state-1 cycle with in_valid=0 produces no valid output.
//   Simultaneous events: none beyond the above; a push and a pop in the same cycle are the normal shift.
// TESTING
//   - Reset: assert rst_n=0 mid-stream -> out_valid=0, dout=0 same cycle; after release, first output only after a new fill.
//   - N=4 ramp, all values in Q.8.
//     - Stimulus: din_r = 256, 512, 768, 1024 at cycles 0-3 (din_i=0, in_valid=1); state 0,0,1,1,2,2; W = 1 at cycles 4 and 5.
//     - out_valid at cycles 3,4 with dout_r = 1024 and 1536.
//   - Twiddle -j, continuing the ramp case with w = 0 - j at cycle 5.
//     - cycle 4 output: -512 + 0j with W = 1.
//     - cycle 5 output: dout_r = 0, dout_i = 512.
//   - Drain: in_valid low after the last sample -> exactly DELAY state-2 outputs valid, then out_valid=0 while state keeps cycling.
//   - Fill stall: in_valid gaps during state 0 -> delay line holds and results equal the gap-free case.
//   - Wrap/rounding: head = (-3, 0), W = 0.5 (128) -> dout_r = -2 (floor); a = b = 2^(DATA_W-1)-1 -> sum wraps to -2.

Source files
------------

// File: rtl/sdf_stage_2.sv
// Radix-2 single-path delay-feedback butterfly stage (2-point delay stage).
// A DELAY-deep {re, im, tag} line feeds x[n]+x[n+D] and (x[n]-x[n+D])*W into a registered output.
module sdf_stage_2 #(
  parameter int DATA_W = 24,
  parameter int FRAC_W = 8,
  parameter int DELAY  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] din_r,
  input  logic signed [DATA_W-1:0] din_i,
  input  logic signed [DATA_W-1:0] w_r,
  input  logic signed [DATA_W-1:0] w_i,
  input  logic        [1:0]        state,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] dout_r,
  output logic signed [DATA_W-1:0] dout_i
);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_BFLY = 2'd1,
    ST_TWID = 2'd2,
    ST_RSVD = 2'd3
  } state_e;

  localparam int          PW    = 2 * DATA_W;
  localparam int unsigned DEPTH = DELAY;

  state_e st;
  assign st = state_e'(state);

  logic signed [DATA_W-1:0] re_q  [DEPTH];
  logic signed [DATA_W-1:0] re_d  [DEPTH];
  logic signed [DATA_W-1:0] im_q  [DEPTH];
  logic signed [DATA_W-1:0] im_d  [DEPTH];
  logic                     tag_q [DEPTH];
  logic                     tag_d [DEPTH];

  logic                     out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0] dout_r_q, dout_r_d;
  logic signed [DATA_W-1:0] dout_i_q, dout_i_d;

  logic signed [DATA_W-1:0] head_r, head_i;
  logic                     head_tag;
  assign head_r   = re_q[0];
  assign head_i   = im_q[0];
  assign head_tag = tag_q[0];

  // Full-width signed products; the floor shift and wrap to DATA_W happen on the final sums.
  logic signed [PW-1:0] ar_x, ai_x, wr_x, wi_x, re_acc, im_acc;
  logic signed [DATA_W-1:0] twd_r, twd_i, sum_r, sum_i, dif_r, dif_i;

  always_comb begin
    ar_x   = PW'(head_r);
    ai_x   = PW'(head_i);
    wr_x   = PW'(w_r);
    wi_x   = PW'(w_i);
    re_acc = (ar_x * wr_x) - (ai_x * wi_x);
    im_acc = (ar_x * wi_x) + (ai_x * wr_x);
    twd_r  = DATA_W'(re_acc >>> FRAC_W);
    twd_i  = DATA_W'(im_acc >>> FRAC_W);
    sum_r  = head_r + din_r;
    sum_i  = head_i + din_i;
    dif_r  = head_r - din_r;
    dif_i  = head_i - din_i;
  end

  logic                     shift;
  logic signed [DATA_W-1:0] push_r, push_i;
  logic                     push_tag;
  logic                     bfly_ok;

  always_comb begin
    shift       = 1'b0;
    push_r      = din_r;
    push_i      = din_i;
    push_tag    = 1'b0;
    out_valid_d = 1'b0;
    dout_r_d    = dout_r_q;
    dout_i_d    = dout_i_q;
    bfly_ok     = in_valid & head_tag;
    re_d        = re_q;
    im_d        = im_q;
    tag_d       = tag_q;

    unique case (st)
      ST_FILL: begin
        shift    = in_valid;
        push_tag = 1'b1;
      end
      ST_BFLY: begin
        shift       = 1'b1;
        push_r      = dif_r;
        push_i      = dif_i;
        push_tag    = bfly_ok;
        out_valid_d = bfly_ok;
        if (bfly_ok) begin
          dout_r_d = sum_r;
          dout_i_d = sum_i;
        end
      end
      ST_TWID: begin
        shift       = 1'b1;
        push_tag    = in_valid;
        out_valid_d = head_tag;
        if (head_tag) begin
          dout_r_d = twd_r;
          dout_i_d = twd_i;
        end
      end
      default: ;
    endcase

    if (shift) begin
      for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
        re_d[i]  = re_q[i+1];
        im_d[i]  = im_q[i+1];
        tag_d[i] = tag_q[i+1];
      end
      re_d[DEPTH-1]  = push_r;
      im_d[DEPTH-1]  = push_i;
      tag_d[DEPTH-1] = push_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        re_q[i]  <= '0;
        im_q[i]  <= '0;
        tag_q[i] <= 1'b0;
      end
      out_valid_q <= 1'b0;
      dout_r_q    <= '0;
      dout_i_q    <= '0;
    end else begin
      re_q        <= re_d;
      im_q        <= im_d;
      tag_q       <= tag_d;
      out_valid_q <= out_valid_d;
      dout_r_q    <= dout_r_d;
      dout_i_q    <= dout_i_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout_r    = dout_r_q;
  assign dout_i    = dout_i_q;

endmodule
